smem_output_writer: RTL and testbench
=====================================

// Module: smem_output_writer
// PURPOSE
//  Downstream sink of the per-batch result store (RAM_curr_mem). Grants output_permit on request,
//  buffers the 512-bit result lines (header + mem entries) in a FIFO, and streams them as
//  consecutive 64-byte line writes to host memory starting at base_addr. Back-pressures the
//  result store through stall; raises done once output_finish is seen and every line is written.
// PARAMETERS
//  DATA_W      512  result line width (bits)
//  ADDR_W      32   host byte-address width
//  FIFO_DEPTH  16   line buffer depth (power of 2, >= 4)
//  SKID        2    free slots reserved for beats in flight after stall rises
//  LINE_BYTES  64   address increment per written line
// PORTS
//  clk             in   1       clock
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       pulse: begin a batch; accepted only in IDLE or DONE
//  base_addr       in   ADDR_W  host address of first line; sampled on accepted start
//  output_request  in   1       result store ready to drain
//  output_permit   out  1       grant to result store
//  output_data     in   DATA_W  result line
//  output_valid    in   1       output_data is a line to capture this cycle
//  output_finish   in   1       result store has emitted all lines (level, stays high)
//  stall           out  1       freeze result store (registered)
//  wr_req          out  1       host write valid
//  wr_addr         out  ADDR_W  host write byte address
//  wr_data         out  DATA_W  host write data
//  wr_ready        in   1       host accepts write when wr_req & wr_ready
//  done            out  1       batch fully written (level, until next accepted start)
//  line_count      out  16      lines written this batch
//  overflow_err    out  1       sticky: push attempted while FIFO full
// BEHAVIOUR
//  Reset (async, any state, mid-batch included): state IDLE, FIFO emptied, all outputs 0.
//  FSM: IDLE -start-> WAIT_REQ -output_request-> GRANT -output_finish-> DRAIN
//       -FIFO empty & no write pending-> DONE -start-> WAIT_REQ.
//   start in WAIT_REQ/GRANT/DRAIN ignored. Accepted start: latch base_addr, line_count<=0,
//   done<=0, overflow_err<=0.
//  output_permit = 1 exactly in GRANT (registered, asserted the cycle after entry).
//  Capture: in GRANT, output_valid=1 pushes output_data; output_valid=0 (inter-group gaps) is no push.
//   Beats with output_valid in other states are dropped.
//  GRANT->DRAIN on first cycle output_finish=1; a beat valid in that same cycle is still pushed.
//  stall registered: next stall = (fifo_count_next >= FIFO_DEPTH-SKID); guarantees room for
//   the one beat the result store registers before seeing stall. Push while full: data
//   dropped, overflow_err<=1 (must never fire in correct operation).
//  Write side: wr_req = FIFO not empty (state GRANT or DRAIN); wr_data = FIFO head (show-ahead);
//   wr_addr = base_addr + line_count*LINE_BYTES, modulo 2^ADDR_W (wraps silently).
//   On wr_req & wr_ready: pop, line_count+1. wr_req/wr_addr/wr_data stable while wr_ready=0.
//  Simultaneous push and pop: count unchanged, both happen; push into full FIFO with a pop in
//   the same cycle is legal (no overflow).
//  Latency: output_valid beat into empty FIFO -> wr_req next cycle.
//  DONE: done=1, output_permit=0, stall=0, wr_req=0. line_count holds final value.
//  line_count wraps at 2^16 (batch max 256 reads * 51 lines fits).
// STRUCTURE
//  Shared package smem_pkg: writer state encoding (IDLE, WAIT_REQ, GRANT, DRAIN, DONE),
//   LINE_BYTES, DATA_W. One sub-module: smem_line_fifo (sync FIFO, show-ahead, count output,
//   async active-low reset). FSM, address generation and stall logic live in the top.
// TESTING
//  1 Reset: assert reset_n=0 mid-GRANT with 5 lines buffered -> all outputs 0, FIFO empty at once.
//  2 Basic: base_addr=0x1000, 3 valid beats then finish, wr_ready=1 -> addrs 0x1000,0x1040,
//    0x1080, data in order, done=1, line_count=3.
//  3 Gaps: beats with output_valid=0 between groups -> no writes for gap cycles, no extra lines.
//  4 Backpressure: wr_ready=0 for 40 cycles, source sends every cycle -> stall rises at count 14,
//    max count 16, overflow_err stays 0, all lines later written in order.
//  5 Wrap: base_addr=0xFFFFFFC0, 2 lines -> addrs 0xFFFFFFC0, 0x00000000.
//  6 Restart: start while in DRAIN ignored; start in DONE with base_addr=0x2000 -> done=0,
//    line_count=0, next batch writes from 0x2000.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared definitions for the result-store output writer: state encoding and line geometry.
package smem_pkg;

    localparam int unsigned DATA_W     = 512;
    localparam int unsigned LINE_BYTES = 64;

    typedef enum logic [2:0] {
        StIdle,
        StWaitReq,
        StGrant,
        StDrain,
        StDone
    } writer_state_e;

endpackage

// File: rtl/smem_output_writer_if.sv
// Result-store drain handshake plus host line-write bus, seen from the writer (master) side.
interface smem_output_writer_if #(
    parameter int unsigned DATA_W = smem_pkg::DATA_W,
    parameter int unsigned ADDR_W = 32
);
    import smem_pkg::*;

    logic              output_request;
    logic              output_permit;
    logic [DATA_W-1:0] output_data;
    logic              output_valid;
    logic              output_finish;
    logic              stall;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        input  output_request, output_data, output_valid, output_finish, wr_ready,
        output output_permit, stall, wr_req, wr_addr, wr_data
    );

    modport slave (
        output output_request, output_data, output_valid, output_finish, wr_ready,
        input  output_permit, stall, wr_req, wr_addr, wr_data
    );

endinterface

// File: rtl/smem_line_fifo.sv
// Synchronous show-ahead line FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module smem_line_fifo #(
    parameter int unsigned Width = 512,
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PtrW:0]    count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible behind a non-zero count.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/smem_output_writer.sv
// Drains result lines from the result store into a FIFO and streams them to host memory
// as consecutive line writes; stalls the store near full and flags batch completion.
module smem_output_writer #(
    parameter int unsigned DATA_W     = smem_pkg::DATA_W,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SKID       = 2,
    parameter int unsigned LINE_BYTES = smem_pkg::LINE_BYTES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    smem_output_writer_if.master bus,
    output logic                 done,
    output logic [15:0]          line_count,
    output logic                 overflow_err
);
    import smem_pkg::*;

    localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AddrShift = $clog2(LINE_BYTES);

    writer_state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       line_count_q, line_count_d;
    logic              permit_q, permit_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    logic              start_acc, wr_req, push, push_ok, pop;
    logic              fifo_empty, fifo_full;
    logic [CntW-1:0]   fifo_count, count_next;
    logic [DATA_W-1:0] fifo_head;

    smem_line_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (bus.output_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign start_acc = start && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_acc) state_d = StWaitReq;
            StWaitReq: if (bus.output_request) state_d = StGrant;
            StGrant:   if (bus.output_finish) state_d = StDrain;
            StDrain:   if (fifo_empty) state_d = StDone;
            StDone:    if (start_acc) state_d = StWaitReq;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_req  = ~fifo_empty && (state_q == StGrant || state_q == StDrain);
        pop     = wr_req & bus.wr_ready;
        push    = (state_q == StGrant) & bus.output_valid;
        push_ok = push & (~fifo_full | pop);

        count_next = fifo_count + CntW'(push_ok) - CntW'(pop);
        // Registered stall: the threshold leaves room for the beat already in flight.
        stall_d    = (count_next >= CntW'(FIFO_DEPTH - SKID));
        permit_d   = (state_d == StGrant);
        done_d     = (state_d == StDone);

        base_d       = base_q;
        line_count_d = line_count_q;
        overflow_d   = overflow_q;
        if (start_acc) begin
            base_d       = base_addr;
            line_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (pop)              line_count_d = line_count_q + 16'd1;
            if (push && !push_ok) overflow_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q       <= '0;
            line_count_q <= '0;
            permit_q     <= 1'b0;
            stall_q      <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            base_q       <= base_d;
            line_count_q <= line_count_d;
            permit_q     <= permit_d;
            stall_q      <= stall_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.output_permit = permit_q;
    assign bus.stall         = stall_q;
    assign bus.wr_req        = wr_req;
    assign bus.wr_addr       = base_q + (ADDR_W'(line_count_q) << AddrShift);
    assign bus.wr_data       = wr_req ? fifo_head : '0;
    assign done              = done_q;
    assign line_count        = line_count_q;
    assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_smem_output_writer.sv
// Randomized self-checking bench for smem_output_writer against a queue-based line model.
module tb_smem_output_writer;

    localparam int unsigned DW = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        done;
    logic [15:0] line_count;
    logic        overflow_err;

    smem_output_writer_if bus ();

    smem_output_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .bus          (bus),
        .done         (done),
        .line_count   (line_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [DW-1:0] exp_q [$];
    bit stall_seen;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_permit"}, bus.output_permit, 0);
        check({tag, "_stall"}, bus.stall, 0);
        check({tag, "_wr_req"}, bus.wr_req, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_line_count"}, line_count, 0);
        check({tag, "_overflow"}, overflow_err, 0);
    endtask

    // One batch: start, drain n lines with gap/ready randomisation, expect completion.
    task automatic run_batch(input logic [31:0] base, input int n, input int gap_pct,
                             input int ready_pct, input int hold_cycles, input bit inject);
        int sent = 0, wr_idx = 0, hold = hold_cycles, max_occ = 0;
        bit fin = 0, injected = 0, stall_prev = 0, waiting = 0;
        logic [31:0] exp_addr, held_addr;
        logic [DW-1:0] held_data;

        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_done", done, 0);
        check("start_line_count", line_count, 0);
        bus.output_request = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("stall", bus.stall, (exp_q.size() >= 14));
            check("line_count_run", line_count, wr_idx);
            if (bus.stall) stall_seen = 1;
            if (waiting) begin
                check("hold_wr_req", bus.wr_req, 1);
                check("hold_wr_addr", bus.wr_addr, held_addr);
                check("hold_wr_data", bus.wr_data, held_data);
            end
            if (done) begin
                fin = 1;
                break;
            end

            if (hold > 0 && bus.output_permit) begin
                bus.wr_ready = 1'b0;
                hold--;
            end else begin
                bus.wr_ready = ($urandom_range(99) < ready_pct);
            end
            start = 1'b0;
            if (inject && !injected && bus.output_finish && !bus.output_permit && bus.wr_req) begin
                bus.wr_ready = 1'b0;
                base_addr = 32'hDEAD_0000;
                start = 1'b1;
                injected = 1;
            end

            waiting = bus.wr_req && !bus.wr_ready;
            held_addr = bus.wr_addr;
            held_data = bus.wr_data;
            if (bus.wr_req && bus.wr_ready) begin
                exp_addr = base + 32'(wr_idx) * 32'd64;
                check("wr_addr", bus.wr_addr, exp_addr);
                if (exp_q.size() == 0) check("wr_unexpected", bus.wr_req, 0);
                else check("wr_data", bus.wr_data, exp_q.pop_front());
                wr_idx++;
            end

            // Source reacts to stall one cycle late, like the registered result store.
            if (bus.output_permit && sent < n && !stall_prev && $urandom_range(99) >= gap_pct) begin
                bus.output_valid = 1'b1;
                bus.output_data = rand_line();
                exp_q.push_back(bus.output_data);
                sent++;
            end else begin
                bus.output_valid = 1'b0;
                bus.output_data = '0;
            end
            if (bus.output_permit && sent == n) bus.output_finish = 1'b1;
            stall_prev = bus.stall;
            if (exp_q.size() > max_occ) max_occ = exp_q.size();
            @(negedge clk);
        end

        start = 1'b0;
        bus.output_valid = 1'b0;
        check("done_timeout", done, 1);
        check("final_line_count", line_count, n);
        check("final_overflow", overflow_err, 0);
        check("final_queue_empty", exp_q.size(), 0);
        check("done_wr_req", bus.wr_req, 0);
        check("done_permit", bus.output_permit, 0);
        check("done_stall", bus.stall, 0);
        check("max_occupancy", (max_occ <= 16), 1);
        if (inject) check("inject_happened", injected, 1);
        exp_q.delete();
        bus.output_request = 1'b0;
        bus.output_finish = 1'b0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        check("done_holds", done, 1);
    endtask

    task automatic reset_mid_grant();
        int beats = 0;
        @(negedge clk);
        base_addr = 32'h3000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.output_request = 1'b1;
        bus.wr_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && beats < 5; cyc++) begin
            if (bus.output_permit) begin
                bus.output_valid = 1'b1;
                bus.output_data = rand_line();
                beats++;
            end
            @(negedge clk);
        end
        bus.output_valid = 1'b0;
        check("rst_pre_permit", bus.output_permit, 1);
        check("rst_pre_wr_req", bus.wr_req, 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("rst_mid");
        bus.output_request = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_post_wr_req", bus.wr_req, 0);
        check("rst_post_permit", bus.output_permit, 0);
    endtask

    initial begin
        bus.output_request = 1'b0;
        bus.output_valid = 1'b0;
        bus.output_finish = 1'b0;
        bus.output_data = '0;
        bus.wr_ready = 1'b0;
        stall_seen = 0;
        #12 check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_batch(32'h0000_1000, 3, 0, 100, 0, 0);
        run_batch(32'h0000_1800, 20, 50, 70, 0, 0);
        stall_seen = 0;
        run_batch(32'h0000_4000, 30, 0, 100, 40, 0);
        check("backpressure_stall_seen", stall_seen, 1);
        reset_mid_grant();
        run_batch(32'hFFFF_FFC0, 2, 0, 100, 0, 0);
        run_batch(32'h0000_5000, 12, 10, 20, 0, 1);
        run_batch(32'h0000_2000, 5, 30, 80, 0, 0);
        for (int b = 0; b < 3; b++) begin
            run_batch($urandom & 32'hFFFF_FFC0, int'($urandom_range(40, 1)),
                      int'($urandom_range(60)), int'($urandom_range(100, 10)),
                      int'($urandom_range(20)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
